// File: rtl/seq_detect_pkg.sv
// -----------------------------------------------------------------------------
// seq_detect_pkg
// Shared definitions for the serial sequence detector:
//   state_t     - FSM state encoding (IDLE=00, LOAD=01, RUN=10), also the value
//                 driven on the detector's 2-bit state output.
//   PAT_W_MIN/  - legal range for the pattern length parameter.
//   PAT_W_MAX
//   pat_w_legal - helper for range checks on a candidate pattern length.
// -----------------------------------------------------------------------------
package seq_detect_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_LOAD = 2'b01,
    ST_RUN  = 2'b10
  } state_t;

  localparam int PAT_W_MIN = 2;
  localparam int PAT_W_MAX = 8;

  function automatic bit pat_w_legal(input int w);
    return (w >= PAT_W_MIN) && (w <= PAT_W_MAX);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Up-counter that sticks at all-ones instead of wrapping.
// Ports:
//   clk   - clock
//   rst_n - synchronous active-low reset, clears the count
//   clr   - synchronous clear (wins over inc)
//   inc   - count up by one when not already saturated
//   cnt   - current count (WIDTH bits)
// -----------------------------------------------------------------------------
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] cnt
);

  logic [WIDTH-1:0] cnt_reg;
  logic [WIDTH-1:0] cnt_next;

  always_comb begin
    cnt_next = cnt_reg;
    if (clr) begin
      cnt_next = '0;
    end else if (inc && (cnt_reg != '1)) begin
      cnt_next = cnt_reg + WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

  assign cnt = cnt_reg;

endmodule

// File: rtl/seq_detect_mealy.sv
// -----------------------------------------------------------------------------
// seq_detect_mealy
// Run-time loadable serial pattern detector (Mealy). A PAT_W-bit pattern is
// shifted in MSB first while in LOAD, then the qualified input stream is
// compared against it in RUN. Overlapping or non-overlapping detection is
// chosen cycle by cycle with the overlap input. Matches since the last load
// are counted in a saturating counter.
//
// Parameters:
//   PAT_W - pattern length in bits (2..8)
//   CNT_W - width of the saturating match counter
//
// Ports:
//   clk        - clock
//   rst_n      - synchronous active-low reset
//   load_start - pulse: go to LOAD, clear history, fill, load count, counter
//   load_valid - qualifies load_bit while in LOAD
//   load_bit   - pattern bit, MSB first
//   in_valid   - qualifies in_bit while in RUN
//   in_bit     - serial data bit
//   overlap    - 1 = overlapping detection, 0 = non-overlapping
//   match      - match strobe, same cycle as the final pattern bit
//   match_cnt  - saturating match count since the last load
//   state      - IDLE=00, LOAD=01, RUN=10
//   pattern_q  - loaded pattern readback
//
// Build option:
//   SEQ_MATCH_REG_EN - when defined, match is registered: it asserts one cycle
//                      after the final bit and is glitch-free. match_cnt timing
//                      does not change.
// -----------------------------------------------------------------------------
module seq_detect_mealy
  import seq_detect_pkg::*;
#(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_start,
  input  logic             load_valid,
  input  logic             load_bit,
  input  logic             in_valid,
  input  logic             in_bit,
  input  logic             overlap,
  output logic             match,
  output logic [CNT_W-1:0] match_cnt,
  output logic [1:0]       state,
  output logic [PAT_W-1:0] pattern_q
);

  // fill and load_cnt both range 0..PAT_W-1
  localparam int              CW       = $clog2(PAT_W);
  localparam logic [CW-1:0]   FILL_MAX = CW'(PAT_W - 1);

  state_t           state_reg,    state_next;
  logic [PAT_W-1:0] pattern_reg,  pattern_next;
  logic [PAT_W-2:0] hist_reg,     hist_next;
  logic [CW-1:0]    fill_reg,     fill_next;
  logic [CW-1:0]    load_cnt_reg, load_cnt_next;

  logic [PAT_W-1:0] window;
  logic             match_raw;

  // Most recent PAT_W-1 history bits with the current bit appended; its low
  // PAT_W-1 bits are also the next history value (covers PAT_W=2 as well).
  assign window = {hist_reg, in_bit};

  // fill==PAT_W-1 guarantees every window bit arrived since the last clear,
  // so stale or reset history can never produce a match.
  assign match_raw = (state_reg == ST_RUN) & in_valid & ~load_start &
                     (fill_reg == FILL_MAX) & (window == pattern_reg);

  always_comb begin
    state_next    = state_reg;
    pattern_next  = pattern_reg;
    hist_next     = hist_reg;
    fill_next     = fill_reg;
    load_cnt_next = load_cnt_reg;

    if (load_start) begin
      // Restart from any state; the old pattern stays visible until new
      // bits overwrite it.
      state_next    = ST_LOAD;
      hist_next     = '0;
      fill_next     = '0;
      load_cnt_next = '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
        end
        ST_LOAD: begin
          if (load_valid) begin
            pattern_next = {pattern_reg[PAT_W-2:0], load_bit};
            if (load_cnt_reg == FILL_MAX) begin
              load_cnt_next = '0;
              state_next    = ST_RUN;
            end else begin
              load_cnt_next = load_cnt_reg + CW'(1);
            end
          end
        end
        ST_RUN: begin
          if (in_valid) begin
            hist_next = window[PAT_W-2:0];
            if (match_raw && !overlap) begin
              // Non-overlapping: the next match needs PAT_W fresh bits.
              fill_next = '0;
            end else if (fill_reg != FILL_MAX) begin
              fill_next = fill_reg + CW'(1);
            end
          end
        end
        default: begin
          state_next = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      pattern_reg  <= '0;
      hist_reg     <= '0;
      fill_reg     <= '0;
      load_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      pattern_reg  <= pattern_next;
      hist_reg     <= hist_next;
      fill_reg     <= fill_next;
      load_cnt_reg <= load_cnt_next;
    end
  end

  // Counter follows the raw match so its timing is the same in both builds.
  sat_counter #(
    .WIDTH (CNT_W)
  ) u_match_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (load_start),
    .inc   (match_raw),
    .cnt   (match_cnt)
  );

`ifdef SEQ_MATCH_REG_EN
  logic match_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      match_reg <= 1'b0;
    end else begin
      match_reg <= match_raw;
    end
  end

  assign match = match_reg;
`else
  assign match = match_raw;
`endif

  assign state     = state_reg;
  assign pattern_q = pattern_reg;

endmodule

// File: tb/tb_seq_detect_mealy.sv
// -----------------------------------------------------------------------------
// tb_seq_detect_mealy
// Two detector instances (PAT_W=4) share all inputs: one with an 8-bit match
// counter, one with a 2-bit counter to exercise saturation. A reference model
// keeps the received bits in a queue and matches on the tail of that queue.
// -----------------------------------------------------------------------------
module tb_seq_detect_mealy;

  localparam int PAT_W = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, load_start, load_valid, load_bit, in_valid, in_bit, overlap;

  logic       match_a, match_b;
  logic [7:0] cnt_a;
  logic [1:0] cnt_b;
  logic [1:0] state_a, state_b;
  logic [3:0] pat_a, pat_b;

  seq_detect_mealy #(.PAT_W(PAT_W), .CNT_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_start (load_start),
    .load_valid (load_valid),
    .load_bit   (load_bit),
    .in_valid   (in_valid),
    .in_bit     (in_bit),
    .overlap    (overlap),
    .match      (match_a),
    .match_cnt  (cnt_a),
    .state      (state_a),
    .pattern_q  (pat_a)
  );

  seq_detect_mealy #(.PAT_W(PAT_W), .CNT_W(2)) dut_sat (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_start (load_start),
    .load_valid (load_valid),
    .load_bit   (load_bit),
    .in_valid   (in_valid),
    .in_bit     (in_bit),
    .overlap    (overlap),
    .match      (match_b),
    .match_cnt  (cnt_b),
    .state      (state_b),
    .pattern_q  (pat_b)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  logic ov     = 1'b0;

  // Reference model state
  bit   m_ready = 0;        // set once a reset edge has been seen
  int   m_state = 0;        // 0 idle, 1 load, 2 run
  int   m_pat   = 0;
  int   m_load_n = 0;
  bit   m_bits[$];          // valid run bits since the last clear
  int   m_cnt   = 0;        // unbounded match count
  bit   m_match_d = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic bit model_match(input bit ib);
    int w;
    if (m_bits.size() < PAT_W - 1) return 1'b0;
    w = 0;
    for (int i = m_bits.size() - (PAT_W - 1); i < m_bits.size(); i++)
      w = (w << 1) | int'(m_bits[i]);
    w = (w << 1) | int'(ib);
    return w == m_pat;
  endfunction

  function automatic int min_i(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  // One clock cycle: drive on the falling edge, check mid low phase,
  // then advance the model to what the next rising edge should produce.
  task automatic step(input logic r, input logic ls, input logic lv, input logic lb,
                      input logic iv, input logic ib, input logic ovl);
    bit raw;
    bit exp_m;
    @(negedge clk);
    rst_n = r; load_start = ls; load_valid = lv; load_bit = lb;
    in_valid = iv; in_bit = ib; overlap = ovl;
    #2;
    raw = (m_state == 2) && iv && !ls && model_match(ib);
`ifdef SEQ_MATCH_REG_EN
    exp_m = m_match_d;
`else
    exp_m = raw;
`endif
    if (m_ready) begin
      check_eq("state",     32'(state_a), 32'(m_state));
      check_eq("pattern_q", 32'(pat_a),   32'(m_pat));
      check_eq("match_cnt", 32'(cnt_a),   32'(min_i(m_cnt, 255)));
      check_eq("sat_cnt",   32'(cnt_b),   32'(min_i(m_cnt, 3)));
      if (r) begin
        check_eq("match",     32'(match_a), 32'(exp_m));
        check_eq("match_sat", 32'(match_b), 32'(exp_m));
      end
    end
    $display("cyc=%0d rst_n=%b ls=%b lv=%b lb=%b iv=%b ib=%b ov=%b | state=%0d pat=%h match=%b cnt=%0d cnt2=%0d",
             cyc, r, ls, lv, lb, iv, ib, ovl, state_a, pat_a, match_a, cnt_a, cnt_b);
    // model update for the coming edge
    if (!r) begin
      m_ready = 1; m_state = 0; m_pat = 0; m_load_n = 0; m_bits.delete(); m_cnt = 0;
      m_match_d = 0;
    end else begin
      m_match_d = raw;
      if (ls) begin
        m_state = 1; m_load_n = 0; m_bits.delete(); m_cnt = 0;
      end else if (m_state == 1) begin
        if (lv) begin
          m_pat = ((m_pat << 1) | int'(lb)) & ((1 << PAT_W) - 1);
          m_load_n++;
          if (m_load_n == PAT_W) begin
            m_state = 2; m_load_n = 0;
          end
        end
      end else if (m_state == 2) begin
        if (iv) begin
          m_bits.push_back(ib);
          if (m_bits.size() > PAT_W) void'(m_bits.pop_front());
          if (raw) begin
            m_cnt++;
            if (!ovl) m_bits.delete();
          end
        end
      end
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ov);
  endtask

  task automatic feed(input logic b);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, b, ov);
  endtask

  task automatic load_pattern(input logic [3:0] p);
    logic [3:0] pv;
    pv = p;
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, ov);
    for (int i = PAT_W - 1; i >= 0; i--) step(1'b1, 1'b0, 1'b1, pv[i], 1'b0, 1'b0, ov);
  endtask

  task automatic feed_word(input logic [15:0] w, input int n);
    logic [15:0] wv;
    wv = w;
    for (int i = n - 1; i >= 0; i--) feed(wv[i]);
  endtask

  initial begin
    rst_n = 1'b0; load_start = 1'b0; load_valid = 1'b0; load_bit = 1'b0;
    in_valid = 1'b0; in_bit = 1'b0; overlap = 1'b0;

    // reset, then load 1011
    step(1'b0, 0, 0, 0, 0, 0, 0);
    step(1'b0, 0, 0, 0, 0, 0, 0);
    idle(2);
    load_pattern(4'b1011);
    idle(1);

    // overlapping: 1011011 -> matches on bits 4 and 7
    ov = 1'b1;
    feed_word(16'b1011011, 7);
    idle(2);

    // non-overlapping: reload, 1011011 then 10110110
    ov = 1'b0;
    load_pattern(4'b1011);
    feed_word(16'b1011011, 7);
    feed_word(16'b10110110, 8);
    idle(2);

    // pattern bits separated by idle gaps
    load_pattern(4'b1011);
    for (int i = 0; i < 4; i++) begin
      feed((i == 1) ? 1'b0 : 1'b1);
      idle(3);
    end

    // saturation: pattern 1111, 10 valid ones, overlapping
    ov = 1'b1;
    load_pattern(4'b1111);
    feed_word(16'h03FF, 10);
    idle(2);

    // load_start on the final bit of a would-be match
    load_pattern(4'b1011);
    feed_word(16'b101, 3);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, ov);
    idle(2);

    // reset mid-RUN
    load_pattern(4'b0110);
    feed_word(16'b011, 3);
    step(1'b0, 0, 0, 0, 0, 0, ov);
    idle(2);

    // randomized traffic
    for (int k = 0; k < 600; k++) begin
      logic r, ls, lv, lb, iv, ib, o;
      r  = ($urandom_range(0, 199) != 0);
      ls = ($urandom_range(0, 39) == 0);
      lv = 1'($urandom_range(0, 1));
      lb = 1'($urandom_range(0, 1));
      iv = r ? ($urandom_range(0, 3) != 0) : 1'b0;
      ib = 1'($urandom_range(0, 1));
      o  = ($urandom_range(0, 3) != 0);
      step(r, ls, lv, lb, iv, ib, o);
    end
    idle(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
